// File: rtl/if_id_reg_pkg.sv
// rtl/if_id_reg_pkg.sv - shared CPU definitions for the IF/ID pipeline register
package if_id_reg_pkg;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFC;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/if_id_reg_sat_counter32.sv
// rtl/if_id_reg_sat_counter32.sv - enabled 32-bit counter that sticks at all-ones
module sat_counter32
    import if_id_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count
);

    // load wins over en so a preset value is never bumped on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with fetch address check and stage counters
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
    parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC4_F,
    input  logic [31:0] PC8_F,
    input  logic        branch_D,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic [4:0]  ExcCode_D,
    output logic        BD_D,
    output logic        valid_D,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] pc_f;
    logic        fault;
    logic [31:0] cap_instr;
    logic [4:0]  cap_exc;
    logic        capture;
    logic        bubble;

    // PC4_F = 0 wraps pc_f to the top of the address space, caught by the range check
    always_comb begin
        pc_f      = PC4_F - 32'd4;
        fault     = (pc_f[1:0] != 2'b00) || (pc_f < PC_BASE) || (pc_f > PC_LIMIT);
        cap_instr = fault ? 32'h0 : Instr_F;
        cap_exc   = fault ? EXC_ADEL : EXC_NONE;
        capture   = !flush && !stall;
        bubble    = flush || stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_D   <= 32'h0;
            PC_D      <= PC_BASE;
            PC4_D     <= PC_BASE + 32'd4;
            PC8_D     <= PC_BASE + 32'd8;
            ExcCode_D <= EXC_NONE;
            BD_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (flush) begin
            // the bubble keeps the fetch PC so an exception handler still sees a usable EPC
            Instr_D   <= 32'h0;
            PC_D      <= pc_f;
            PC4_D     <= PC4_F;
            PC8_D     <= PC8_F;
            ExcCode_D <= EXC_NONE;
            BD_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (!stall) begin
            Instr_D   <= cap_instr;
            PC_D      <= pc_f;
            PC4_D     <= PC4_F;
            PC8_D     <= PC8_F;
            ExcCode_D <= cap_exc;
            BD_D      <= branch_D & valid_D;
            valid_D   <= 1'b1;
        end
    end

    sat_counter32 u_fetch_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .en         (capture),
        .load       (1'b0),
        .load_value (32'h0),
        .count      (fetch_cnt)
    );

    sat_counter32 u_bubble_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .en         (bubble),
        .load       (1'b0),
        .load_value (32'h0),
        .count      (bubble_cnt)
    );

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter PC_BASE, default 32'h0000_3000, lowest legal fetch address.
REQ-002 Parameter PC_LIMIT, default 32'h0000_6FFC, highest legal fetch address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard stall from hazard unit; hold D-stage contents.
REQ-006 flush  input  1  squash D stage (exception/eret redirect).
REQ-007 Instr_F  input  32  fetched instruction.
REQ-008 PC4_F  input  32  fetch PC + 4.
REQ-009 PC8_F  input  32  fetch PC + 8.
REQ-010 branch_D  input  1  instruction currently in D is a branch/jump.
REQ-011 Instr_D  output  32  instruction to decode.
REQ-012 PC_D, PC4_D, PC8_D  output  32 each  PC, PC+4, PC+8 of Instr_D.
REQ-013 ExcCode_D  output  5  fetch exception code; 0 = none.
REQ-014 BD_D  output  1  Instr_D is a branch delay slot.
REQ-015 valid_D  output  1  D stage holds a real instruction.
REQ-016 fetch_cnt  output  32  count of valid instructions entering D.
REQ-017 bubble_cnt  output  32  count of cycles D stage was empty or held.

Function
REQ-018 PC_F SHALL be derived internally as PC4_F - 32'd4 (modulo 2^32).
REQ-019 Fetch fault SHALL be PC_F[1:0] != 0, or PC_F < PC_BASE, or PC_F > PC_LIMIT.
REQ-020 On fault, capture SHALL store Instr_D = 32'h0, ExcCode_D = 5'd4 (AdEL), PC fields unchanged from fetch.
REQ-021 Without fault, capture SHALL store Instr_F verbatim and ExcCode_D = 0.
REQ-022 Priority per edge SHALL be: flush > stall > capture.
REQ-023 flush SHALL set Instr_D = 0, ExcCode_D = 0, BD_D = 0, valid_D = 0; PC_D/PC4_D/PC8_D SHALL load the current fetch values so the bubble carries a valid EPC.
REQ-024 stall (no flush) SHALL hold every output register unchanged.
REQ-025 Capture SHALL set valid_D = 1 and BD_D = branch_D & valid_D (sampled pre-edge).
REQ-026 Latency SHALL be exactly one cycle from F inputs to D outputs; no combinational path from inputs to outputs.
REQ-027 fetch_cnt SHALL increment by 1 on each capture edge, including faulting captures; saturate at 32'hFFFF_FFFF.
REQ-028 bubble_cnt SHALL increment by 1 on each edge with flush or stall asserted; saturate at 32'hFFFF_FFFF.
REQ-029 Simultaneous flush and stall SHALL count once in bubble_cnt and not in fetch_cnt.
REQ-030 PC4_F wrap (PC4_F = 0 gives PC_F = 32'hFFFF_FFFC) SHALL raise a fault by the range rule.

Reset
REQ-031 reset low SHALL immediately force Instr_D = 0, PC_D = PC_BASE, PC4_D = PC_BASE + 4, PC8_D = PC_BASE + 8, ExcCode_D = 0, BD_D = 0, valid_D = 0, fetch_cnt = 0, bubble_cnt = 0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override both; first capture SHALL occur on the first rising edge with reset high and stall/flush low.

Structure
REQ-033 ExcCode constants (EXC_NONE = 0, EXC_ADEL = 4), PC_BASE and PC_LIMIT defaults SHALL live in the shared CPU definitions package.
REQ-034 One sub-module, sat_counter32 (enable, saturating 32-bit), SHALL be instantiated twice for fetch_cnt and bubble_cnt.
REQ-035 Fault detection SHALL be a combinational block inside if_id_reg; no other sub-modules.

Verification
REQ-036 Reset low, then high; PC4_F = 32'h3004, Instr_F = 32'h3C01_1234 -> next edge Instr_D = 32'h3C01_1234, PC_D = 32'h3000, valid_D = 1, fetch_cnt = 1.
REQ-037 Capture, then stall = 1 for 3 edges with new Instr_F -> Instr_D unchanged, bubble_cnt = 3, fetch_cnt unchanged.
REQ-038 PC4_F = 32'h3006 -> ExcCode_D = 4, Instr_D = 0, PC_D = 32'h3002; PC4_F = 32'h7004 -> ExcCode_D = 4.
REQ-039 flush = 1 and stall = 1 same edge -> valid_D = 0, Instr_D = 0, PC_D = current PC_F, bubble_cnt += 1.
REQ-040 valid beq in D with branch_D = 1, next capture -> BD_D = 1; following capture with branch_D = 0 -> BD_D = 0.
REQ-041 Reset pulsed low between edges during stall -> outputs reach reset values before the next edge; counters preloaded to 32'hFFFF_FFFE saturate at 32'hFFFF_FFFF.
